// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between vga_timing_gen and its consumers.
// Carries the pixel strobe in, and sync, display and fetch outputs.
//
// Ports (master = generator side):
//   pix_ce       in   pixel clock-enable strobe
//   hs, vs       out  horizontal / vertical sync
//   de           out  display pixel visible
//   x, y, addr   out  display coordinate and linear address
//   fetch_*      out  position LEAD pixels ahead of display
//   vblank       out  display line in vertical blanking
//   sof, sol     out  start-of-frame / start-of-line pulses
interface vga_timing_gen_if #(
    parameter int CW = 12,
    parameter int AW = 19
);
    logic          pix_ce;
    logic          hs;
    logic          vs;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [AW-1:0] addr;
    logic          fetch_valid;
    logic [CW-1:0] fetch_x;
    logic [CW-1:0] fetch_y;
    logic [AW-1:0] fetch_addr;
    logic          vblank;
    logic          sof;
    logic          sol;

    modport master (
        input  pix_ce,
        output hs, vs, de, x, y, addr,
        output fetch_valid, fetch_x, fetch_y, fetch_addr,
        output vblank, sof, sol
    );

    modport slave (
        output pix_ce,
        input  hs, vs, de, x, y, addr,
        input  fetch_valid, fetch_x, fetch_y, fetch_addr,
        input  vblank, sof, sol
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with a lead "fetch" position.
// Advances one pixel per clock with bus.pix_ce; all outputs registered.
//
// Ports:
//   clock    in   system clock
//   rst_n_i  in   synchronous active-low reset
//   bus      vga_timing_gen_if.master (pix_ce in, timing outputs out)
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int LEAD     = 2,
    parameter int CW       = 12,
    parameter int AW       = 19
) (
    input logic              clock,
    input logic              rst_n_i,
    vga_timing_gen_if.master bus
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FRONT);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FRONT);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [CW-1:0] F_H0   = CW'(LEAD - 1);
    localparam logic          HS_ON  = (HS_POL != 0);
    localparam logic          VS_ON  = (VS_POL != 0);

    // The fetch pair starts LEAD-1 pixels into line 0, so the next
    // visible fetch pixel already has LEAD (or H_ACTIVE) pixels before it.
    localparam logic [AW-1:0] F_A0 =
        AW'((LEAD < H_ACTIVE) ? LEAD : H_ACTIVE);

    function automatic logic [CW-1:0] inc_h(input logic [CW-1:0] h);
        return (h == H_LAST) ? '0 : h + CW'(1);
    endfunction

    function automatic logic [CW-1:0] inc_v(input logic [CW-1:0] h,
                                            input logic [CW-1:0] v);
        if (h != H_LAST) return v;
        return (v == V_LAST) ? '0 : v + CW'(1);
    endfunction

    function automatic logic visible(input logic [CW-1:0] h,
                                     input logic [CW-1:0] v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

    // counter state
    logic [CW-1:0] h_q, v_q;
    logic [CW-1:0] fh_q, fv_q;
    // address the next visible pixel of each pair will receive
    logic [AW-1:0] na_q, fna_q;

    // registered outputs
    logic          hs_q, vs_q, de_q, vb_q, sof_q, sol_q, fvld_q;
    logic [CW-1:0] x_q, y_q, fx_q, fy_q;
    logic [AW-1:0] a_q, fa_q;

    // next position and its decode
    logic [CW-1:0] h_n, v_n, fh_n, fv_n;
    logic          de_n, fde_n;
    logic [AW-1:0] base, fbase;
    logic [AW-1:0] a_n, fa_n, na_n, fna_n;

    always_comb begin
        h_n   = inc_h(h_q);
        v_n   = inc_v(h_q, v_q);
        fh_n  = inc_h(fh_q);
        fv_n  = inc_v(fh_q, fv_q);
        de_n  = visible(h_n, v_n);
        fde_n = visible(fh_n, fv_n);

        // Running address restarts at the top of each frame; it only
        // counts visible pixels, so blanking simply holds it.
        base  = (h_n == '0 && v_n == '0) ? '0 : na_q;
        a_n   = de_n ? base : '0;
        na_n  = de_n ? base + AW'(1) : base;

        fbase = (fh_n == '0 && fv_n == '0) ? '0 : fna_q;
        fa_n  = fde_n ? fbase : '0;
        fna_n = fde_n ? fbase + AW'(1) : fbase;
    end

    always_ff @(posedge clock) begin
        if (!rst_n_i) begin
            h_q    <= H_LAST;
            v_q    <= V_LAST;
            fh_q   <= F_H0;
            fv_q   <= '0;
            na_q   <= '0;
            fna_q  <= F_A0;
            hs_q   <= ~HS_ON;
            vs_q   <= ~VS_ON;
            de_q   <= 1'b0;
            vb_q   <= 1'b1;
            sof_q  <= 1'b0;
            sol_q  <= 1'b0;
            fvld_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            a_q    <= '0;
            fx_q   <= '0;
            fy_q   <= '0;
            fa_q   <= '0;
        end else if (bus.pix_ce) begin
            h_q    <= h_n;
            v_q    <= v_n;
            fh_q   <= fh_n;
            fv_q   <= fv_n;
            na_q   <= na_n;
            fna_q  <= fna_n;
            hs_q   <= (h_n >= HS_BEG && h_n < HS_END) ? HS_ON : ~HS_ON;
            vs_q   <= (v_n >= VS_BEG && v_n < VS_END) ? VS_ON : ~VS_ON;
            de_q   <= de_n;
            vb_q   <= (v_n >= V_ACT);
            sof_q  <= (h_n == '0) && (v_n == '0);
            sol_q  <= (h_n == '0);
            fvld_q <= fde_n;
            x_q    <= de_n ? h_n : '0;
            y_q    <= de_n ? v_n : '0;
            a_q    <= a_n;
            fx_q   <= fde_n ? fh_n : '0;
            fy_q   <= fde_n ? fv_n : '0;
            fa_q   <= fa_n;
        end else begin
            // pulses last exactly one clock; levels hold
            sof_q  <= 1'b0;
            sol_q  <= 1'b0;
        end
    end

    assign bus.hs          = hs_q;
    assign bus.vs          = vs_q;
    assign bus.de          = de_q;
    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.addr        = a_q;
    assign bus.fetch_valid = fvld_q;
    assign bus.fetch_x     = fx_q;
    assign bus.fetch_y     = fy_q;
    assign bus.fetch_addr  = fa_q;
    assign bus.vblank      = vb_q;
    assign bus.sof         = sof_q;
    assign bus.sol         = sol_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen in a small 8x4 mode with LEAD=3.
// Table vectors, directed sequences and random strobes vs a model.
module tb_vga_timing_gen;

    localparam int HA    = 8;
    localparam int HF    = 1;
    localparam int HSW   = 2;
    localparam int HB    = 1;
    localparam int VA    = 4;
    localparam int VF    = 1;
    localparam int VSW   = 1;
    localparam int VB    = 1;
    localparam int LEAD  = 3;
    localparam int HT    = HA + HF + HSW + HB;
    localparam int VT    = VA + VF + VSW + VB;
    localparam int FRAME = HT * VT;
    localparam bit HPOL  = 1'b1;
    localparam bit VPOL  = 1'b1;

    typedef struct packed {
        logic       sof;
        logic       sol;
        logic       de;
        logic       hs;
        logic       vs;
        logic       vblank;
        logic       fv;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] addr;
        logic [7:0] fx;
        logic [7:0] fy;
        logic [7:0] fa;
    } outs_t;

    typedef struct {
        bit    r;
        bit    c;
        outs_t e;
    } vec_t;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    vga_timing_gen_if #(.CW(8), .AW(8)) bus ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HSW), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VSW), .V_BACK(VB),
        .HS_POL(1), .VS_POL(1), .LEAD(LEAD), .CW(8), .AW(8)
    ) dut (
        .clock  (clock),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference: linear raster index, plus "still in reset" and "strobed"
    int m_pos    = FRAME - 1;
    bit m_fresh  = 1'b1;
    bit m_strobe = 1'b0;

    function automatic outs_t mk(bit sof, bit sol, bit de, bit hs, bit vs,
                                 bit vb, bit fv, int x, int y, int a,
                                 int fx, int fy, int fa);
        outs_t o;
        o.sof = sof; o.sol = sol; o.de = de; o.hs = hs; o.vs = vs;
        o.vblank = vb; o.fv = fv;
        o.x = 8'(x); o.y = 8'(y); o.addr = 8'(a);
        o.fx = 8'(fx); o.fy = 8'(fy); o.fa = 8'(fa);
        return o;
    endfunction

    function automatic outs_t sample();
        outs_t s;
        s.sof = bus.sof; s.sol = bus.sol; s.de = bus.de;
        s.hs = bus.hs; s.vs = bus.vs; s.vblank = bus.vblank;
        s.fv = bus.fetch_valid;
        s.x = bus.x; s.y = bus.y; s.addr = bus.addr;
        s.fx = bus.fetch_x; s.fy = bus.fetch_y; s.fa = bus.fetch_addr;
        return s;
    endfunction

    function automatic outs_t mexp();
        outs_t o;
        int h, v, fp, fh, fv;
        bit d, fd;
        o = '0;
        if (m_fresh) begin
            o.vblank = 1'b1;
            o.hs = ~HPOL;
            o.vs = ~VPOL;
            return o;
        end
        h  = m_pos % HT;
        v  = m_pos / HT;
        fp = (m_pos + LEAD) % FRAME;
        fh = fp % HT;
        fv = fp / HT;
        d  = (h < HA) && (v < VA);
        fd = (fh < HA) && (fv < VA);
        o.de = d;
        o.x = d ? 8'(h) : 8'd0;
        o.y = d ? 8'(v) : 8'd0;
        o.addr = d ? 8'(v * HA + h) : 8'd0;
        o.fv = fd;
        o.fx = fd ? 8'(fh) : 8'd0;
        o.fy = fd ? 8'(fv) : 8'd0;
        o.fa = fd ? 8'(fv * HA + fh) : 8'd0;
        o.hs = (h >= HA + HF && h < HA + HF + HSW) ? HPOL : ~HPOL;
        o.vs = (v >= VA + VF && v < VA + VF + VSW) ? VPOL : ~VPOL;
        o.vblank = (v >= VA);
        o.sof = m_strobe && (m_pos == 0);
        o.sol = m_strobe && (h == 0);
        return o;
    endfunction

    task automatic mstep(input bit r, input bit c);
        if (!r) begin
            m_pos = FRAME - 1; m_fresh = 1'b1; m_strobe = 1'b0;
        end else if (c) begin
            m_pos = (m_pos + 1) % FRAME; m_fresh = 1'b0; m_strobe = 1'b1;
        end else begin
            m_strobe = 1'b0;
        end
    endtask

    task automatic chk_out(input string name, input outs_t got,
                           input outs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic apply(input bit r, input bit c, output outs_t got);
        rst_n = r;
        bus.pix_ce = c;
        @(posedge clock);
        mstep(r, c);
        #1;
        got = sample();
    endtask

    task automatic cyc(input bit r, input bit c, input string tag);
        outs_t g;
        apply(r, c, g);
        chk_out(tag, g, mexp());
    endtask

    vec_t tbl[13];
    outs_t got;
    int sofk[$];
    int ah[$], dh[$], fah[$], fvh[$];
    int de_cnt, hs_cnt, guard;

    initial begin
        rst_n = 1'b0;
        bus.pix_ce = 1'b0;

        tbl[0]  = '{0, 1, mk(0,0,0,0,0,1,0, 0,0,0, 0,0,0)};
        tbl[1]  = '{1, 0, mk(0,0,0,0,0,1,0, 0,0,0, 0,0,0)};
        tbl[2]  = '{1, 1, mk(1,1,1,0,0,0,1, 0,0,0, 3,0,3)};
        tbl[3]  = '{1, 0, mk(0,0,1,0,0,0,1, 0,0,0, 3,0,3)};
        tbl[4]  = '{1, 1, mk(0,0,1,0,0,0,1, 1,0,1, 4,0,4)};
        tbl[5]  = '{1, 1, mk(0,0,1,0,0,0,1, 2,0,2, 5,0,5)};
        tbl[6]  = '{1, 1, mk(0,0,1,0,0,0,1, 3,0,3, 6,0,6)};
        tbl[7]  = '{1, 1, mk(0,0,1,0,0,0,1, 4,0,4, 7,0,7)};
        tbl[8]  = '{1, 1, mk(0,0,1,0,0,0,0, 5,0,5, 0,0,0)};
        tbl[9]  = '{1, 1, mk(0,0,1,0,0,0,0, 6,0,6, 0,0,0)};
        tbl[10] = '{1, 1, mk(0,0,1,0,0,0,0, 7,0,7, 0,0,0)};
        tbl[11] = '{1, 1, mk(0,0,0,0,0,0,0, 0,0,0, 0,0,0)};
        tbl[12] = '{1, 1, mk(0,0,0,1,0,0,1, 0,0,0, 0,1,8)};

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].c, got);
            chk_out($sformatf("vec%0d", i), got, tbl[i].e);
        end

        // continuous strobe: three frames
        cyc(0, 1, "cont_rst");
        de_cnt = 0;
        hs_cnt = 0;
        for (int k = 1; k <= 3 * FRAME; k++) begin
            cyc(1, 1, "cont");
            if (bus.sof) sofk.push_back(k);
            if (k <= FRAME && bus.de) de_cnt++;
            if (k <= HT && bus.hs) hs_cnt++;
            ah.push_back(int'(bus.addr));
            dh.push_back(int'(bus.de));
            fah.push_back(int'(bus.fetch_addr));
            fvh.push_back(int'(bus.fetch_valid));
        end
        chk_int("de_per_frame", de_cnt, HA * VA);
        chk_int("hs_per_line", hs_cnt, HSW);
        chk_int("sof_count", sofk.size(), 3);
        if (sofk.size() >= 2) begin
            chk_int("sof_first", sofk[0], 1);
            chk_int("sof_period", sofk[1] - sofk[0], FRAME);
        end
        for (int k = 0; k + LEAD < ah.size(); k++) begin
            chk_int("fetch_lead_valid", dh[k + LEAD], fvh[k]);
            if (fvh[k] != 0)
                chk_int("fetch_lead_addr", fah[k], ah[k + LEAD]);
        end

        // alternating strobe doubles the frame period
        sofk.delete();
        cyc(0, 1, "tog_rst");
        for (int k = 1; k <= 4 * FRAME + 10; k++) begin
            cyc(1, (k % 2) == 1, "toggle");
            if (bus.sof) sofk.push_back(k);
        end
        chk_int("tog_sof_count", sofk.size(), 3);
        if (sofk.size() >= 2)
            chk_int("tog_sof_period", sofk[1] - sofk[0], 2 * FRAME);

        // reset mid-frame at v=2, h=5
        cyc(0, 1, "mid_pre_rst");
        guard = 0;
        while (m_pos != 2 * HT + 5 && guard < 2 * FRAME) begin
            cyc(1, 1, "mid_run");
            guard++;
        end
        chk_int("mid_reach", m_pos, 2 * HT + 5);
        cyc(0, 1, "mid_rst");
        chk_int("mid_rst_vblank", int'(bus.vblank), 1);
        cyc(1, 1, "mid_restart");
        chk_int("mid_restart_sof", int'(bus.sof), 1);

        // random strobes with occasional resets
        cyc(0, 1, "rnd_rst");
        for (int k = 0; k < 1500; k++)
            cyc(($urandom % 150) != 0, ($urandom % 3) != 0, "random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
